// File: rtl/lfsr_galois_checker.sv
// lfsr_galois_checker: self-synchronising PRBS checker for the Galois LFSR generator
module lfsr_galois_checker #(
  parameter int                  NB_LFSR    = 8,
  parameter logic [NB_LFSR-1:0]  TAPS       = 8'h1D,
  parameter int                  LOCK_CNT   = 3,
  parameter int                  UNLOCK_CNT = 4,
  parameter int                  ERR_W      = 16
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_soft_reset,
  input  logic               i_valid,
  input  logic [NB_LFSR-1:0] i_lfsr,
  output logic               o_lock,
  output logic               o_bad_word,
  output logic [ERR_W-1:0]   o_err_cnt
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  typedef enum logic [1:0] {SEED, CHECK, LOCKED} state_t;
  state_t             state;
  logic [NB_LFSR-1:0] exp_word;
  logic [GW-1:0]      good_cnt;
  logic [BW-1:0]      bad_cnt;
  logic               hit;
  function automatic logic [NB_LFSR-1:0] nxt(input logic [NB_LFSR-1:0] x);
    return {x[NB_LFSR-2:0], 1'b0} ^ (x[NB_LFSR-1] ? TAPS : '0);
  endfunction
  assign hit    = (i_lfsr == exp_word);
  assign o_lock = (state == LOCKED);
  // Seed from a nonzero word, confirm LOCK_CNT predictions, then flywheel and count deviations
  always_ff @(posedge clk) begin
    if (i_rst || i_soft_reset) begin
      state      <= SEED;
      exp_word   <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      o_err_cnt  <= '0;
      o_bad_word <= 1'b0;
    end else begin
      o_bad_word <= 1'b0;
      if (i_valid) begin
        case (state)
          SEED: if (|i_lfsr) begin
            exp_word <= nxt(i_lfsr);
            good_cnt <= '0;
            state    <= CHECK;
          end
          CHECK: if (hit) begin
            exp_word <= nxt(i_lfsr);
            good_cnt <= good_cnt + GW'(1);
            if (good_cnt == GW'(LOCK_CNT - 1)) begin
              state   <= LOCKED;
              bad_cnt <= '0;
            end
          end else if (|i_lfsr) begin
            exp_word <= nxt(i_lfsr);
            good_cnt <= '0;
          end else begin
            state <= SEED;
          end
          LOCKED: begin
            exp_word <= nxt(exp_word);
            if (hit) begin
              bad_cnt <= '0;
            end else begin
              o_bad_word <= 1'b1;
              bad_cnt    <= bad_cnt + BW'(1);
              if (~&o_err_cnt) o_err_cnt <= o_err_cnt + ERR_W'(1);
              if (bad_cnt == BW'(UNLOCK_CNT - 1)) state <= SEED;
            end
          end
          default: state <= SEED;
        endcase
      end
    end
  end
endmodule
